// File: rtl/filter_pkg.sv
// Shared definitions for the row-buffered 3x3 filter and its line scheduler.
// Contents: pixel width, RGB565 field positions, default row length, and the
// scheduler FSM state encoding.
package filter_pkg;

  localparam int unsigned PIX_W = 16;

  // RGB565 field positions within a pixel word
  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  localparam int unsigned DEFAULT_BLOCK_LENGTH = 240;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_END,
    RD_SET,
    RD_WAIT,
    EMIT,
    ROW_END,
    DONE
  } sched_state_t;

endpackage

// File: rtl/filter_line_scheduler_if.sv
// Pixel stream and filter-control bundle between the line scheduler and its
// environment (source, 3x3 filter, sink).
//   master : scheduler side (drives src_ready, f_*, dst_valid/dst_data)
//   slave  : environment side (drives src_valid/src_data, f_d_out/f_d_rdy,
//            dst_ready)
interface filter_line_scheduler_if
  import filter_pkg::*;
#(
  parameter int unsigned CURSOR_W = 10
) ();

  logic                src_valid;
  logic [PIX_W-1:0]    src_data;
  logic                src_ready;

  logic [PIX_W-1:0]    f_d_in;
  logic                f_wren;
  logic [CURSOR_W-1:0] f_cursor;
  logic [PIX_W-1:0]    f_d_out;
  logic                f_d_rdy;

  logic                dst_valid;
  logic [PIX_W-1:0]    dst_data;
  logic                dst_ready;

  modport master (
    input  src_valid, src_data,
    output src_ready,
    output f_d_in, f_wren, f_cursor,
    input  f_d_out, f_d_rdy,
    output dst_valid, dst_data,
    input  dst_ready
  );

  modport slave (
    output src_valid, src_data,
    input  src_ready,
    input  f_d_in, f_wren, f_cursor,
    output f_d_out, f_d_rdy,
    input  dst_valid, dst_data,
    output dst_ready
  );

endinterface

// File: rtl/filter_src_loader.sv
// Row write-burst engine: accepts BLOCK_LENGTH source beats per row and writes
// them into the filter's row buffer.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start_row           pulse: begin accepting one row
//   row_done            pulse: last word written, f_wren dropped
//   src_valid/src_data  source beat in; src_ready out
//   cur_set/cur_val     read-side cursor positioning from the top FSM
//   f_d_in, f_wren, f_cursor  registered filter write port
module filter_src_loader
  import filter_pkg::*;
#(
  parameter int unsigned BLOCK_LENGTH = DEFAULT_BLOCK_LENGTH,
  parameter int unsigned CURSOR_W     = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_row,
  output logic                row_done,
  input  logic                src_valid,
  input  logic [PIX_W-1:0]    src_data,
  output logic                src_ready,
  input  logic                cur_set,
  input  logic [CURSOR_W-1:0] cur_val,
  output logic [PIX_W-1:0]    f_d_in,
  output logic                f_wren,
  output logic [CURSOR_W-1:0] f_cursor
);

  localparam logic [CURSOR_W-1:0] LAST_COL = CURSOR_W'(BLOCK_LENGTH - 1);

  logic [CURSOR_W-1:0] col;
  logic                tail;
  logic                beat;

  assign beat = src_valid & src_ready;

  // f_wren rises once per row and stays high through stalls; the filter
  // rotates its row buffers on that single rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col       <= '0;
      tail      <= 1'b0;
      row_done  <= 1'b0;
      src_ready <= 1'b0;
      f_d_in    <= '0;
      f_wren    <= 1'b0;
      f_cursor  <= '0;
    end else begin
      row_done <= 1'b0;
      if (start_row) begin
        src_ready <= 1'b1;
        col       <= '0;
      end
      // The cursor register is shared: load beats own it during a burst,
      // the top FSM positions it for reads otherwise.
      if (beat) begin
        f_d_in   <= src_data;
        f_cursor <= col;
        col      <= col + 1'b1;
        f_wren   <= 1'b1;
        if (col == LAST_COL) begin
          src_ready <= 1'b0;
          tail      <= 1'b1;
        end
      end else if (cur_set) begin
        f_cursor <= cur_val;
      end
      // One extra cycle of f_wren so the final word is written.
      if (tail) begin
        tail     <= 1'b0;
        f_wren   <= 1'b0;
        row_done <= 1'b1;
        col      <= '0;
      end
    end
  end

endmodule

// File: rtl/filter_line_scheduler.sv
// Frame sequencer for the 3x3 row-buffered filter. Loads one source row per
// write burst, primes two rows, then sweeps interior columns of each further
// row and forwards each filtered pixel downstream.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start        single-cycle frame start (ignored unless idle)
//   busy         high from accepted start until done
//   done         one-cycle pulse after the last output pixel
//   row_idx      row currently being loaded
//   bus          master side of the source / filter / sink bundle
module filter_line_scheduler
  import filter_pkg::*;
#(
  parameter int unsigned BLOCK_LENGTH = DEFAULT_BLOCK_LENGTH,
  parameter int unsigned NUM_ROWS     = 320,
  parameter int unsigned CURSOR_W     = 10,
  parameter int unsigned ROW_W        = 9,
  parameter int unsigned SETTLE_CYC   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ROW_W-1:0]         row_idx,
  filter_line_scheduler_if.master  bus
);

  localparam int unsigned          SET_W       = $clog2(SETTLE_CYC + 2);
  localparam logic [SET_W-1:0]     SETTLE_MAX  = SET_W'(SETTLE_CYC);
  localparam logic [CURSOR_W-1:0]  LAST_RD_COL = CURSOR_W'(BLOCK_LENGTH - 2);
  localparam logic [ROW_W-1:0]     LAST_ROW    = ROW_W'(NUM_ROWS - 1);
  localparam logic [ROW_W-1:0]     PRIME_ROWS  = ROW_W'(2);

  sched_state_t        state;
  logic [CURSOR_W-1:0] rd_col;
  logic [SET_W-1:0]    settle;
  logic                start_row;
  logic                row_done;
  logic                cur_set;
  logic [CURSOR_W-1:0] cur_val;
  logic                dst_valid;
  logic [PIX_W-1:0]    dst_data;

  logic                ld_src_ready;
  logic [PIX_W-1:0]    ld_d_in;
  logic                ld_wren;
  logic [CURSOR_W-1:0] ld_cursor;

  always_comb begin
    cur_set = 1'b0;
    cur_val = '0;
    if (state == RD_SET) begin
      cur_set = 1'b1;
      cur_val = rd_col;
    end else if (state == ROW_END) begin
      cur_set = 1'b1;
    end
  end

  filter_src_loader #(
    .BLOCK_LENGTH (BLOCK_LENGTH),
    .CURSOR_W     (CURSOR_W)
  ) u_loader (
    .clk       (clk),
    .reset     (reset),
    .start_row (start_row),
    .row_done  (row_done),
    .src_valid (bus.src_valid),
    .src_data  (bus.src_data),
    .src_ready (ld_src_ready),
    .cur_set   (cur_set),
    .cur_val   (cur_val),
    .f_d_in    (ld_d_in),
    .f_wren    (ld_wren),
    .f_cursor  (ld_cursor)
  );

  assign bus.src_ready = ld_src_ready;
  assign bus.f_d_in    = ld_d_in;
  assign bus.f_wren    = ld_wren;
  assign bus.f_cursor  = ld_cursor;
  assign bus.dst_valid = dst_valid;
  assign bus.dst_data  = dst_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      row_idx   <= '0;
      rd_col    <= '0;
      settle    <= '0;
      start_row <= 1'b0;
      dst_valid <= 1'b0;
      dst_data  <= '0;
    end else begin
      start_row <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            row_idx   <= '0;
            busy      <= 1'b1;
            start_row <= 1'b1;
          end
        end
        LOAD: begin
          if (row_done) state <= LOAD_END;
        end
        LOAD_END: begin
          if (row_idx < PRIME_ROWS) begin
            state <= ROW_END;
          end else begin
            rd_col <= CURSOR_W'(1);
            state  <= RD_SET;
          end
        end
        RD_SET: begin
          settle <= '0;
          state  <= RD_WAIT;
        end
        RD_WAIT: begin
          // f_d_rdy is only trusted once the cursor has been held long enough.
          if (settle == SETTLE_MAX) begin
            if (bus.f_d_rdy) begin
              dst_data  <= bus.f_d_out;
              dst_valid <= 1'b1;
              state     <= EMIT;
            end
          end else begin
            settle <= settle + 1'b1;
          end
        end
        EMIT: begin
          if (bus.dst_ready) begin
            dst_valid <= 1'b0;
            if (rd_col == LAST_RD_COL) begin
              state <= ROW_END;
            end else begin
              rd_col <= rd_col + 1'b1;
              state  <= RD_SET;
            end
          end
        end
        ROW_END: begin
          rd_col <= '0;
          if (row_idx == LAST_ROW) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            row_idx   <= row_idx + 1'b1;
            state     <= LOAD;
            start_row <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/filter_line_scheduler.md
Name: filter_line_scheduler

Overview:
- Sequencer for the 3x3 row-buffered 2D filter (RGB565, 240 px rows).
- Streams source pixels into the filter one row per write burst, primes the first two rows, then sweeps the read cursor over interior pixels and forwards each filtered result downstream.
- Owns the filter's wren, cursor and d_in, and consumes its d_out and d_rdy.

Parameters:
- BLOCK_LENGTH, 240, pixels per row; cursor range 0..BLOCK_LENGTH-1.
- NUM_ROWS, 320, rows per frame; must be at least 3.
- CURSOR_W, 10, filter cursor width.
- ROW_W, 9, row counter width.
- SETTLE_CYC, 3, minimum cycles the cursor is held before f_d_rdy is honoured.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle frame start request
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last output pixel is accepted
- row_idx  out  ROW_W  index of the row currently being loaded
- src_valid  in  1  source pixel valid
- src_data  in  16  source pixel, RGB565
- src_ready  out  1  scheduler accepts a source pixel
- f_d_in  out  16  pixel to filter, registered
- f_wren  out  1  filter row write enable
- f_cursor  out  CURSOR_W  filter cursor, registered
- f_d_out  in  16  filter result
- f_d_rdy  in  1  filter result ready
- dst_valid  out  1  filtered pixel valid
- dst_data  out  16  filtered pixel, RGB565
- dst_ready  in  1  sink accepts pixel

Behaviour:
- Reset, asynchronous: state=IDLE. busy, done, src_ready, f_wren and dst_valid = 0. f_cursor, f_d_in, dst_data and row_idx = 0. All counters cleared.
- Reset mid-frame aborts immediately with no done pulse. The filter shares the same reset, so its row rotation realigns.
- FSM states: IDLE, LOAD, LOAD_END, RD_SET, RD_WAIT, EMIT, ROW_END, DONE.
- IDLE: on start, go to LOAD with row_idx=0 and busy=1. start is ignored in every other state.
- LOAD:
  - src_ready=1.
  - Each accepted beat (src_valid & src_ready) registers f_d_in<=src_data and f_cursor<=column count, then increments the column count.
  - f_wren rises the cycle after the first accepted beat and stays high, continuously, for the rest of the row. This gives exactly one wren rising edge per row, which the filter uses to rotate rows.
  - Source stalls hold f_cursor and f_d_in, so rewriting the same word is harmless.
  - After beat BLOCK_LENGTH is accepted, src_ready=0 and the state goes to LOAD_END.
- LOAD_END:
  - f_wren held for one more cycle so the last word is written, then dropped to 0.
  - If row_idx<2 (priming), go to ROW_END. Otherwise go to RD_SET with column=1.
- RD_SET: f_cursor<=column and f_wren=0. Clear the settle counter. Go to RD_WAIT.
- RD_WAIT:
  - Count cycles.
  - When settle count >= SETTLE_CYC and f_d_rdy=1: dst_data<=f_d_out, dst_valid<=1, go to EMIT.
  - f_d_rdy is ignored before SETTLE_CYC.
- EMIT:
  - Hold dst_valid and dst_data until dst_ready. dst_data is stable while valid.
  - On acceptance: dst_valid<=0.
  - If column==BLOCK_LENGTH-2, go to ROW_END. Otherwise column++ and go to RD_SET.
- ROW_END:
  - If row_idx==NUM_ROWS-1, go to DONE. Otherwise row_idx++ and go to LOAD.
  - Column and f_cursor reset to 0.
- DONE: done=1 for one cycle, busy<=0, go to IDLE.
- Frame totals:
  - Source beats: NUM_ROWS*BLOCK_LENGTH.
  - Output pixels: (NUM_ROWS-2)*(BLOCK_LENGTH-2).
  - Outputs are emitted in raster order over interior columns 1..BLOCK_LENGTH-2.
- Minimum read latency per output pixel is 1+SETTLE_CYC cycles plus sink stall.
- f_wren is never high in RD_* or EMIT. src_ready and dst_valid are never high in the same cycle.
- Width rules:
  - Column counter is CURSOR_W bits and never exceeds BLOCK_LENGTH.
  - Compare against BLOCK_LENGTH-1 and BLOCK_LENGTH-2 with no wrap.

Decomposition:
- Shared package filter_pkg:
  - FSM state enum (8 states, 3 bits).
  - Pixel width constant 16.
  - RGB565 field constants (R 15:11, G 10:5, B 4:0).
  - Default BLOCK_LENGTH=240.
- One natural sub-module: filter_src_loader. It contains the LOAD/LOAD_END write-burst logic, i.e. the src handshake, f_wren hold and cursor/data registers, with a start_row/row_done handshake to the top FSM.

Test Plan:
- Param BLOCK_LENGTH=8, NUM_ROWS=5, with a behavioural filter model (d_out = cursor-tagged centre pixel, d_rdy when cursor stable 3 cycles). Full frame with src_valid and dst_ready tied high, then check:
  - exactly 40 src beats and 18 dst pixels;
  - columns 1..6 for rows 2..4;
  - done pulses once, busy then drops.
- Priming: over rows 0 and 1, dst_valid stays 0 and f_wren shows exactly 2 rising edges. The third rising edge precedes the first dst_valid.
- Source stall: src_valid low for 4 cycles at column 3 -> f_cursor holds 3, f_d_in unchanged, f_wren stays high, and no extra row rotation occurs.
- Sink backpressure: dst_ready low for 10 cycles on the first output -> dst_data stable, f_cursor stays 1, no pixel dropped or duplicated.
- Early rdy: f_d_rdy forced high throughout -> the first capture happens no earlier than 3 cycles after the f_cursor update.
- Reset at the 5th output pixel -> all outputs return to reset values asynchronously and there is no done pulse. A new start then yields a full 18-pixel frame.
